// File: rtl/float_acc_pkg.sv
// float_acc_pkg: shared types and constants for the sequential float accumulator.
package float_acc_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned DP_W   = 28;

    localparam int unsigned EXP_BIAS = 127;
    localparam logic [7:0]  EXP_MAX  = 8'hFF;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_ROUND = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Zero and subnormal inputs become a signed zero.
    function automatic logic [31:0] flush_subnormal(input logic [31:0] f);
        if (f[30:23] == '0) begin
            return {f[31], 31'd0};
        end
        return f;
    endfunction

endpackage

// File: rtl/float_acc_seq_lzc.sv
// float_lzc: combinational 28-bit leading-zero counter (all-zero input gives 28).
module float_lzc (
    input  logic [27:0] val,
    output logic [4:0]  cnt
);

    logic found;

    // Scan from the MSB; the first set bit fixes the count.
    always_comb begin
        cnt   = 5'd28;
        found = 1'b0;
        for (int unsigned i = 0; i < 28; i++) begin
            if (!found && val[27 - i]) begin
                cnt   = 5'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/float_acc_seq.sv
// float_acc_seq: multi-cycle IEEE-754 single accumulator over TERMS products.
// Optional feature: define FLOAT_ACC_RNE_EN for round-to-nearest-even,
// otherwise results are truncated toward zero.
import float_acc_pkg::*;

module float_acc_seq #(
    parameter int unsigned TERMS = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    localparam logic [7:0] TERMS_C = 8'(TERMS);

    state_e            state_q, state_d;
    logic [31:0]       acc_q, acc_d;
    logic [7:0]        count_q, count_d;
    logic [31:0]       opb_q, opb_d;
    logic              special_q, special_d;
    logic [31:0]       spec_res_q, spec_res_d;
    logic              sign_q, sign_d;
    logic              eff_sub_q, eff_sub_d;
    logic [EXP_W:0]    exp_q, exp_d;
    logic [DP_W-2:0]   ma_q, ma_d;
    logic [DP_W-2:0]   mb_q, mb_d;
    logic [DP_W-1:0]   sum_q, sum_d;
    logic [DP_W-2:0]   nmant_q, nmant_d;
    logic              nzero_q, nzero_d;

    logic [31:0]       op_x, op_y, op_a, op_b;
    logic              x_nan, y_nan, x_inf, y_inf, swap;
    logic [7:0]        exp_diff;
    logic [4:0]        sh_amt;
    logic [DP_W-2:0]   ext_b, sh_mask, al_b;
    logic [4:0]        lz_cnt, norm_sh;
    logic              norm_under;
    logic              rnd_inc;
    logic              unused_grs;
    logic [24:0]       rnd_mant;
    logic [EXP_W:0]    rnd_exp;
    logic [31:0]       rnd_res;

    float_lzc u_lzc (
        .val (sum_q),
        .cnt (lz_cnt)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = acc_q;

    // Operand classification, magnitude swap and sticky-preserving alignment.
    always_comb begin
        op_x     = acc_q;
        op_y     = opb_q;
        x_nan    = (op_x[30:23] == EXP_MAX) && (op_x[22:0] != '0);
        y_nan    = (op_y[30:23] == EXP_MAX) && (op_y[22:0] != '0);
        x_inf    = (op_x[30:23] == EXP_MAX) && (op_x[22:0] == '0);
        y_inf    = (op_y[30:23] == EXP_MAX) && (op_y[22:0] == '0);
        swap     = (op_y[30:0] > op_x[30:0]);
        op_a     = swap ? op_y : op_x;
        op_b     = swap ? op_x : op_y;
        exp_diff = op_a[30:23] - op_b[30:23];
        sh_amt   = (exp_diff > 8'd27) ? 5'd27 : exp_diff[4:0];
        ext_b    = {(op_b[30:23] != '0), op_b[22:0], 3'b000};
        // A 27-bit shift of 1 wraps to 0, so a cap of 27 yields an all-ones mask.
        sh_mask  = (27'd1 << sh_amt) - 27'd1;
        al_b     = (ext_b >> sh_amt) | {26'd0, |(ext_b & sh_mask)};
    end

    // Normalize shift amount and underflow check, then rounding of the NORM result.
    always_comb begin
        norm_sh    = lz_cnt - 5'd1;
        norm_under = ({4'd0, norm_sh} >= exp_q);
`ifdef FLOAT_ACC_RNE_EN
        rnd_inc    = nmant_q[2] & (nmant_q[1] | nmant_q[0] | nmant_q[3]);
        unused_grs = 1'b0;
`else
        rnd_inc    = 1'b0;
        unused_grs = ^nmant_q[2:0];
`endif
        rnd_mant = {1'b0, nmant_q[26:3]} + {24'd0, rnd_inc};
        rnd_exp  = exp_q + {8'd0, rnd_mant[24]};
        if (special_q) begin
            rnd_res = spec_res_q;
        end else if (nzero_q) begin
            rnd_res = '0;
        end else if (rnd_exp >= 9'd255) begin
            rnd_res = {sign_q, POS_INF[30:0]};
        end else begin
            // On mantissa carry the fraction bits are already zero.
            rnd_res = {sign_q, rnd_exp[7:0], rnd_mant[22:0]};
        end
    end

    // FSM next-state and register updates.
    // Specials still walk ADD and NORM so every term has the same latency.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        opb_d      = opb_q;
        special_d  = special_q;
        spec_res_d = spec_res_q;
        sign_d     = sign_q;
        eff_sub_d  = eff_sub_q;
        exp_d      = exp_q;
        ma_d       = ma_q;
        mb_d       = mb_q;
        sum_d      = sum_q;
        nmant_d    = nmant_q;
        nzero_d    = nzero_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (count_q == '0) begin
                        acc_d   = flush_subnormal(in_data);
                        count_d = 8'd1;
                        if (TERMS_C == 8'd1) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        opb_d   = flush_subnormal(in_data);
                        state_d = ST_ALIGN;
                    end
                end
            end
            ST_ALIGN: begin
                special_d  = 1'b1;
                spec_res_d = QNAN;
                if (x_nan || y_nan) begin
                    spec_res_d = QNAN;
                end else if (x_inf && y_inf && (op_x[31] != op_y[31])) begin
                    spec_res_d = QNAN;
                end else if (x_inf) begin
                    spec_res_d = op_x;
                end else if (y_inf) begin
                    spec_res_d = op_y;
                end else begin
                    special_d = 1'b0;
                end
                sign_d    = op_a[31];
                eff_sub_d = op_a[31] ^ op_b[31];
                exp_d     = {1'b0, op_a[30:23]};
                ma_d      = {(op_a[30:23] != '0), op_a[22:0], 3'b000};
                mb_d      = al_b;
                state_d   = ST_ADD;
            end
            ST_ADD: begin
                sum_d   = eff_sub_q ? ({1'b0, ma_q} - {1'b0, mb_q})
                                    : ({1'b0, ma_q} + {1'b0, mb_q});
                state_d = ST_NORM;
            end
            ST_NORM: begin
                nzero_d = 1'b0;
                if (sum_q[27]) begin
                    nmant_d = {sum_q[27:2], |sum_q[1:0]};
                    exp_d   = exp_q + 9'd1;
                end else if ((sum_q == '0) || norm_under) begin
                    nzero_d = 1'b1;
                end else begin
                    nmant_d = sum_q[26:0] << norm_sh;
                    exp_d   = exp_q - {4'd0, norm_sh};
                end
                state_d = ST_ROUND;
            end
            ST_ROUND: begin
                acc_d   = rnd_res;
                count_d = count_q + 8'd1;
                state_d = (count_d == TERMS_C) ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    acc_d   = '0;
                    count_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            count_q    <= '0;
            opb_q      <= '0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            sign_q     <= 1'b0;
            eff_sub_q  <= 1'b0;
            exp_q      <= '0;
            ma_q       <= '0;
            mb_q       <= '0;
            sum_q      <= '0;
            nmant_q    <= '0;
            nzero_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            opb_q      <= opb_d;
            special_q  <= special_d;
            spec_res_q <= spec_res_d;
            sign_q     <= sign_d;
            eff_sub_q  <= eff_sub_d;
            exp_q      <= exp_d;
            ma_q       <= ma_d;
            mb_q       <= mb_d;
            sum_q      <= sum_d;
            nmant_q    <= nmant_d;
            nzero_q    <= nzero_d;
        end
    end

endmodule

// File: tb/tb_float_acc_seq.sv
// Directed bench for float_acc_seq: instances with TERMS=9, 2 and 1.
module tb_float_acc_seq;

    logic clk;
    logic reset;

    logic        v9, ir9, ov9, r9;
    logic [31:0] d9, od9;
    logic        v2, ir2, ov2, r2;
    logic [31:0] d2, od2;
    logic        v1, ir1, ov1, r1;
    logic [31:0] d1, od1;

    int unsigned tests;
    int unsigned fails;

    float_acc_seq #(.TERMS(9)) u9 (
        .clk(clk), .reset(reset), .in_valid(v9), .in_ready(ir9), .in_data(d9),
        .out_valid(ov9), .out_ready(r9), .out_data(od9)
    );

    float_acc_seq #(.TERMS(2)) u2 (
        .clk(clk), .reset(reset), .in_valid(v2), .in_ready(ir2), .in_data(d2),
        .out_valid(ov2), .out_ready(r2), .out_data(od2)
    );

    float_acc_seq #(.TERMS(1)) u1 (
        .clk(clk), .reset(reset), .in_valid(v1), .in_ready(ir1), .in_data(d1),
        .out_valid(ov1), .out_ready(r1), .out_data(od1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int unsigned w);
        case (w)
            9:       return ir9;
            2:       return ir2;
            default: return ir1;
        endcase
    endfunction

    function automatic logic ovl(input int unsigned w);
        case (w)
            9:       return ov9;
            2:       return ov2;
            default: return ov1;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, then presents one term for one edge.
    // Returns 1 time unit after the accepting edge.
    task automatic send(input int unsigned w, input logic [31:0] d);
        int unsigned n;
        n = 0;
        while (!rdy(w) && n < 20) begin
            step();
            n++;
        end
        chk("send_ready", {31'd0, rdy(w)}, 32'd1);
        case (w)
            9:       begin v9 = 1'b1; d9 = d; end
            2:       begin v2 = 1'b1; d2 = d; end
            default: begin v1 = 1'b1; d1 = d; end
        endcase
        step();
        v9 = 1'b0;
        v2 = 1'b0;
        v1 = 1'b0;
    endtask

    task automatic wait_out(input int unsigned w);
        int unsigned n;
        n = 0;
        while (!ovl(w) && n < 20) begin
            step();
            n++;
        end
        chk("out_valid_seen", {31'd0, ovl(w)}, 32'd1);
    endtask

    task automatic handshake(input int unsigned w);
        case (w)
            9:       r9 = 1'b1;
            2:       r2 = 1'b1;
            default: r1 = 1'b1;
        endcase
        step();
        r9 = 1'b0;
        r2 = 1'b0;
        r1 = 1'b0;
    endtask

    task automatic run2(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
        send(2, a);
        send(2, b);
        wait_out(2);
        chk(tag, od2, exp);
        handshake(2);
    endtask

    logic [31:0] held;

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        v9 = 1'b0; d9 = '0; r9 = 1'b0;
        v2 = 1'b0; d2 = '0; r2 = 1'b0;
        v1 = 1'b0; d1 = '0; r1 = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, ir9}, 32'd1);
        chk("rst_out_valid", {31'd0, ov9}, 32'd0);
        chk("rst_out_data", od9, 32'h0000_0000);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Nine 1.0 terms with per-term handshake timing.
        for (int unsigned k = 0; k < 9; k++) begin
            send(9, 32'h3F80_0000);
            if (k == 0) begin
                chk("first_term_ready", {31'd0, ir9}, 32'd1);
            end else begin
                for (int unsigned c = 0; c < 4; c++) begin
                    chk("busy_ready_low", {31'd0, ir9}, 32'd0);
                    chk("busy_no_valid", {31'd0, ov9}, 32'd0);
                    step();
                end
                if (k < 8) chk("ready_after_4", {31'd0, ir9}, 32'd1);
                else       chk("valid_after_4", {31'd0, ov9}, 32'd1);
            end
        end
        chk("sum_nine_ones", od9, 32'h4110_0000);

        // Back-pressure in DONE.
        held = od9;
        for (int unsigned c = 0; c < 10; c++) begin
            step();
            chk("hold_valid", {31'd0, ov9}, 32'd1);
            chk("hold_data", od9, held);
            chk("hold_ready", {31'd0, ir9}, 32'd0);
        end
        handshake(9);
        chk("post_hs_ready", {31'd0, ir9}, 32'd1);
        chk("post_hs_valid", {31'd0, ov9}, 32'd0);
        chk("post_hs_acc", od9, 32'h0000_0000);

        // Two-term windows.
        run2("cancel_norm", 32'h3F80_0000, 32'hBF40_0000, 32'h3E80_0000);
        run2("exact_zero",  32'h3FC0_0000, 32'hBFC0_0000, 32'h0000_0000);
`ifdef FLOAT_ACC_RNE_EN
        run2("round_075ulp", 32'h3F80_0000, 32'h33C0_0000, 32'h3F80_0001);
`else
        run2("round_075ulp", 32'h3F80_0000, 32'h33C0_0000, 32'h3F80_0000);
`endif
        run2("subnormal_flush", 32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000);
        run2("inf_minus_inf",   32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
        run2("overflow_inf",    32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
        run2("nan_in",          32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000);
        run2("one_inf",         32'h3F80_0000, 32'hFF80_0000, 32'hFF80_0000);
        run2("two_plus_three",  32'h4000_0000, 32'h4040_0000, 32'h40A0_0000);
        run2("neg_two_plus_one", 32'hC000_0000, 32'h3F80_0000, 32'hBF80_0000);
        run2("one_plus_neg_two", 32'h3F80_0000, 32'hC000_0000, 32'hBF80_0000);
        run2("one_plus_one",     32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);

        // TERMS==1: valid right after the accepting edge.
        send(1, 32'h4049_0FDB);
        chk("t1_valid", {31'd0, ov1}, 32'd1);
        chk("t1_data", od1, 32'h4049_0FDB);
        handshake(1);
        send(1, 32'h8000_0005);
        chk("t1_neg_sub", od1, 32'h8000_0000);
        handshake(1);

        // Reset mid-window (during ADD of the fifth term).
        for (int unsigned k = 0; k < 4; k++) send(9, 32'h3F80_0000);
        send(9, 32'h3F80_0000);
        step();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, ov9}, 32'd0);
        chk("midrst_ready", {31'd0, ir9}, 32'd1);
        chk("midrst_acc", od9, 32'h0000_0000);
        for (int unsigned k = 0; k < 9; k++) send(9, 32'h4000_0000);
        wait_out(9);
        chk("sum_nine_twos", od9, 32'h4190_0000);
        handshake(9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
